io_input_conditioner: RTL and testbench

- Conditions raw board inputs before they reach the memory-mapped IO block.
  - Inputs: 4 slide switches and the 36-bit input GPIO header.
  - Per bit: 2-flop synchronizer, then a sampled debounce filter.
- Drives the clean switch and GPIO levels that the IO memory exposes as read-only addresses.
- Adds one-cycle event strobes so software-visible state can be latched or counted.

---
 rtl/io_input_conditioner_pkg.sv | 21 ++
 rtl/io_input_conditioner_debounce_bit.sv | 55 +++++
 rtl/io_input_conditioner.sv | 81 ++++++++
 tb/tb_io_input_conditioner.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_input_conditioner_pkg.sv
// io_cond_pkg: shared defaults and width helper for the board input conditioner.
// Rev 1.0
`default_nettype none

package io_cond_pkg;

  localparam int IO_NUM_SW         = 4;
  localparam int IO_NUM_GPIO       = 36;
  localparam int IO_TICK_DIV       = 50000;
  localparam int IO_STABLE_SAMPLES = 4;

  // A divide-by-one prescaler still needs a 1-bit counter to stay legal.
  function automatic int presc_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

  localparam int PRESC_W = presc_width(IO_TICK_DIV);

endpackage

`default_nettype wire

// File: rtl/io_input_conditioner_debounce_bit.sv
// debounce_bit: 2-flop synchronizer plus sampled N-of-N debounce filter for one pin.
// Rev 1.0
`default_nettype none

module debounce_bit
  import io_cond_pkg::*;
#(
  parameter int STABLE_SAMPLES = IO_STABLE_SAMPLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  input  logic tick,
  output logic clean,
  output logic rise,
  output logic fall,
  output logic accept
);

  logic                      sync1;
  logic                      sync2;
  logic [STABLE_SAMPLES-1:0] hist;
  logic [STABLE_SAMPLES-1:0] hist_next;

  assign hist_next = {hist[STABLE_SAMPLES-2:0], sync2};

  // Pre-register update flag, exported so the top can register a shared strobe
  // in the same cycle the clean level moves.
  assign accept = tick && (hist_next == {STABLE_SAMPLES{sync2}}) && (sync2 != clean);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      hist  <= '0;
      clean <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      rise  <= accept && sync2;
      fall  <= accept && !sync2;
      if (tick) begin
        hist <= hist_next;
      end
      if (accept) begin
        clean <= sync2;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/io_input_conditioner.sv
// io_input_conditioner: synchronizes and debounces switches and GPIO inputs, with event strobes.
// Rev 1.0
`default_nettype none

module io_input_conditioner
  import io_cond_pkg::*;
#(
  parameter int NUM_SW         = IO_NUM_SW,
  parameter int NUM_GPIO       = IO_NUM_GPIO,
  parameter int TICK_DIV       = IO_TICK_DIV,
  parameter int STABLE_SAMPLES = IO_STABLE_SAMPLES
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_SW-1:0]   sw_raw,
  input  logic [NUM_GPIO-1:0] gpio_raw,
  output logic [NUM_SW-1:0]   sw_clean,
  output logic [NUM_GPIO-1:0] gpio_clean,
  output logic [NUM_SW-1:0]   sw_rise,
  output logic                gpio_change,
  output logic                sample_tick
);

  localparam int               CNT_W   = presc_width(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0]    cnt;
  logic [NUM_SW-1:0]   sw_fall;
  logic [NUM_SW-1:0]   sw_accept;
  logic [NUM_GPIO-1:0] gpio_rise;
  logic [NUM_GPIO-1:0] gpio_fall;
  logic [NUM_GPIO-1:0] gpio_accept;
  logic                unused_strobes;

  assign unused_strobes = ^{sw_fall, sw_accept, gpio_rise, gpio_fall};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      sample_tick <= 1'b0;
      gpio_change <= 1'b0;
    end else begin
      sample_tick <= (cnt == CNT_MAX);
      cnt         <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
      gpio_change <= |gpio_accept;
    end
  end

  for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
    debounce_bit #(
      .STABLE_SAMPLES(STABLE_SAMPLES)
    ) u_db (
      .clk    (clk),
      .rst    (rst),
      .raw    (sw_raw[i]),
      .tick   (sample_tick),
      .clean  (sw_clean[i]),
      .rise   (sw_rise[i]),
      .fall   (sw_fall[i]),
      .accept (sw_accept[i])
    );
  end

  for (genvar i = 0; i < NUM_GPIO; i++) begin : g_gpio
    debounce_bit #(
      .STABLE_SAMPLES(STABLE_SAMPLES)
    ) u_db (
      .clk    (clk),
      .rst    (rst),
      .raw    (gpio_raw[i]),
      .tick   (sample_tick),
      .clean  (gpio_clean[i]),
      .rise   (gpio_rise[i]),
      .fall   (gpio_fall[i]),
      .accept (gpio_accept[i])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_io_input_conditioner.sv
// tb_io_input_conditioner: randomized and directed checks against a run-length reference model.
// Rev 1.0
`default_nettype none

module tb_io_input_conditioner;

  localparam int T   = 4;
  localparam int S   = 3;
  localparam int NSW = 4;
  localparam int NG  = 36;
  localparam int NB  = NSW + NG;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NSW-1:0] sw_raw = '0;
  logic [NG-1:0]  gpio_raw = '0;
  logic [NSW-1:0] sw_clean, sw_rise;
  logic [NG-1:0]  gpio_clean;
  logic           gpio_change, sample_tick;

  logic [NSW-1:0] sw_raw_b = '0;
  logic [NG-1:0]  gpio_raw_b = '0;
  logic [NSW-1:0] sw_clean_b, sw_rise_b;
  logic [NG-1:0]  gpio_clean_b;
  logic           gpio_change_b, sample_tick_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  io_input_conditioner #(.NUM_SW(NSW), .NUM_GPIO(NG), .TICK_DIV(T), .STABLE_SAMPLES(S)) dut (
    .clk(clk), .rst(rst), .sw_raw(sw_raw), .gpio_raw(gpio_raw),
    .sw_clean(sw_clean), .gpio_clean(gpio_clean), .sw_rise(sw_rise),
    .gpio_change(gpio_change), .sample_tick(sample_tick));

  io_input_conditioner #(.NUM_SW(NSW), .NUM_GPIO(NG), .TICK_DIV(1), .STABLE_SAMPLES(2)) dut_b (
    .clk(clk), .rst(rst), .sw_raw(sw_raw_b), .gpio_raw(gpio_raw_b),
    .sw_clean(sw_clean_b), .gpio_clean(gpio_clean_b), .sw_rise(sw_rise_b),
    .gpio_change(gpio_change_b), .sample_tick(sample_tick_b));

  // Reference model: a pin's accepted level is the sample value once it has been
  // seen on S consecutive sample edges; samples lag the pin by two clock edges.
  logic [NB-1:0] m_clean = '0, m_rise = '0, m_runval = '0, m_samp = '0;
  logic          m_chg = 1'b0, m_tick = 1'b0;
  int            m_runlen[NB];
  int            m_k = 0;
  logic [NB-1:0] rawq[$];
  logic [NB-1:0] raw_all;
  logic [45:0]   obs, exp_vec;

  assign raw_all = {gpio_raw, sw_raw};
  assign obs     = {sw_clean, gpio_clean, sw_rise, gpio_change, sample_tick};
  assign exp_vec = {m_clean[NSW-1:0], m_clean[NB-1:NSW], m_rise[NSW-1:0], m_chg, m_tick};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_clean = '0; m_rise = '0; m_chg = 1'b0; m_tick = 1'b0; m_k = 0;
      m_runval = '0;
      rawq.delete();
      for (int b = 0; b < NB; b++) m_runlen[b] = S;
    end else begin
      m_samp = (rawq.size() >= 2) ? rawq[rawq.size()-2] : '0;
      m_rise = '0;
      m_chg  = 1'b0;
      if (m_k >= T && (m_k % T) == 0) begin
        for (int b = 0; b < NB; b++) begin
          if (m_samp[b] == m_runval[b]) begin
            if (m_runlen[b] < S) m_runlen[b]++;
          end else begin
            m_runval[b] = m_samp[b];
            m_runlen[b] = 1;
          end
          if (m_runlen[b] >= S && m_samp[b] != m_clean[b]) begin
            m_clean[b] = m_samp[b];
            if (b < NSW) m_rise[b] = m_samp[b];
            else         m_chg = 1'b1;
          end
        end
      end
      m_tick = ((m_k % T) == T - 1);
      rawq.push_back(raw_all);
      if (rawq.size() > 4) void'(rawq.pop_front());
      m_k++;
    end
  end

  task automatic test_reset();
    int ticks;
    ticks = 0;
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (obs !== 46'b0) begin
      errors++; $display("FAIL reset_a got=%h want=0", obs);
    end
    checks++;
    if ({sw_clean_b, gpio_clean_b, sw_rise_b, gpio_change_b, sample_tick_b} !== 46'b0) begin
      errors++; $display("FAIL reset_b got=%h want=0",
                         {sw_clean_b, gpio_clean_b, sw_rise_b, gpio_change_b, sample_tick_b});
    end
    rst = 1'b0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_vec) begin
        errors++; $display("FAIL idle cyc=%0d got=%h want=%h", j, obs, exp_vec);
      end
      if (sample_tick) ticks++;
    end
    checks++;
    if (ticks != 10) begin
      errors++; $display("FAIL idle_tick_count got=%0d want=10", ticks);
    end
  endtask

  task automatic test_step_latency();
    int seen;
    seen = -1;
    sw_raw[2] = 1'b1;
    for (int j = 0; j < 30; j++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_vec) begin
        errors++; $display("FAIL step cyc=%0d got=%h want=%h", j, obs, exp_vec);
      end
      if (seen < 0 && sw_clean[2]) begin
        seen = j;
        checks++;
        if (sw_rise !== 4'b0100) begin
          errors++; $display("FAIL step_rise got=%b want=0100", sw_rise);
        end
      end else if (seen >= 0 && j == seen + 1) begin
        checks++;
        if (sw_rise !== 4'b0000) begin
          errors++; $display("FAIL step_rise_len got=%b want=0000", sw_rise);
        end
      end
    end
    checks++;
    if (seen < 10 || seen > 13) begin
      errors++; $display("FAIL step_latency got=%0d want=10..13", seen);
    end
  endtask

  task automatic test_glitch();
    int pulses;
    pulses = 0;
    gpio_raw[17] = 1'b1;
    for (int j = 0; j < 30; j++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_vec) begin
        errors++; $display("FAIL glitch cyc=%0d got=%h want=%h", j, obs, exp_vec);
      end
      if (gpio_change) pulses++;
      if (j == 5) gpio_raw[17] = 1'b0;
    end
    checks++;
    if (pulses != 0 || gpio_clean[17] !== 1'b0) begin
      errors++; $display("FAIL glitch_reject got pulses=%0d clean=%b want 0/0", pulses, gpio_clean[17]);
    end
  endtask

  task automatic test_simultaneous();
    int pulses, t0, t35;
    pulses = 0; t0 = -1; t35 = -1;
    gpio_raw[0]  = 1'b1;
    gpio_raw[35] = 1'b1;
    for (int j = 0; j < 30; j++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_vec) begin
        errors++; $display("FAIL simul cyc=%0d got=%h want=%h", j, obs, exp_vec);
      end
      if (gpio_change) pulses++;
      if (t0 < 0 && gpio_clean[0])   t0 = j;
      if (t35 < 0 && gpio_clean[35]) t35 = j;
    end
    checks++;
    if (pulses != 1 || t0 < 0 || t0 != t35) begin
      errors++; $display("FAIL simul_pulse got pulses=%0d t0=%0d t35=%0d want 1 pulse, equal times",
                         pulses, t0, t35);
    end
  endtask

  task automatic test_reset_mid();
    int rises;
    rises = 0;
    sw_raw[1] = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (sw_clean[1] !== 1'b1) begin
      errors++; $display("FAIL rmid_setup got=%b want=1", sw_clean[1]);
    end
    sw_raw[1] = 1'b0;
    for (int j = 0; j < 10 && !sample_tick; j++) @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (obs !== 46'b0) begin
      errors++; $display("FAIL rmid_async got=%h want=0", obs);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 30; j++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_vec) begin
        errors++; $display("FAIL rmid cyc=%0d got=%h want=%h", j, obs, exp_vec);
      end
      if (sw_rise[1]) rises++;
    end
    checks++;
    if (rises != 0 || sw_clean[1] !== 1'b0) begin
      errors++; $display("FAIL rmid_hold got rises=%0d clean=%b want 0/0", rises, sw_clean[1]);
    end
  endtask

  task automatic test_random();
    logic [NB-1:0] mask;
    for (int j = 0; j < 600; j++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_vec) begin
        errors++; $display("FAIL random cyc=%0d got=%h want=%h", j, obs, exp_vec);
      end
      if ($urandom_range(0, 5) == 0) begin
        mask = NB'({$urandom, $urandom} & {$urandom, $urandom});
        {gpio_raw, sw_raw} = {gpio_raw, sw_raw} ^ mask;
      end
    end
  endtask

  task automatic test_fast();
    int seen;
    seen = -1;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      checks++;
      if (sample_tick_b !== 1'b1) begin
        errors++; $display("FAIL fast_tick got=%b want=1", sample_tick_b);
      end
    end
    gpio_raw_b[5] = 1'b1;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      if (seen < 0 && gpio_clean_b[5]) begin
        seen = j;
        checks++;
        if (gpio_change_b !== 1'b1) begin
          errors++; $display("FAIL fast_change got=%b want=1", gpio_change_b);
        end
      end
    end
    checks++;
    if (seen != 3) begin
      errors++; $display("FAIL fast_latency got=%0d want=3", seen);
    end
  endtask

  initial begin
    test_reset();
    test_step_latency();
    test_glitch();
    test_simultaneous();
    test_reset_mid();
    test_random();
    test_fast();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
